// File: rtl/multi_ch_timer.sv
// Multi-channel periodic enable timer: cold-boot delay, then NUM_CH outputs sharing a shadowed period/high time.
// Optional build macro MULTI_CH_TIMER_PHASE_EN staggers channel start counts by PHASE_STEP.
module multi_ch_timer #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned COLD_BOOT_CYCLE  = 20,
  parameter int unsigned FULL_CYCLE       = 23,
  parameter int unsigned OUTPUT_UP_PERIOD = 16,
  parameter int unsigned PHASE_STEP       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_we,
  input  logic              cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [NUM_CH-1:0] o,
  output logic [CNT_W-1:0]  cnt0,
  output logic              wrap,
  output logic              counting
);

  localparam int unsigned COLD_W = $clog2(COLD_BOOT_CYCLE + 1);

`ifdef MULTI_CH_TIMER_PHASE_EN
  localparam int unsigned PHASE_STEP_EFF = PHASE_STEP;
`else
  // Phasing disabled: every channel starts at 0, so all outputs match channel 0.
  localparam int unsigned PHASE_STEP_EFF = PHASE_STEP * 0;
`endif

  localparam logic [0:0] S_COLD_BOOT = 1'b0;
  localparam logic [0:0] S_COUNT     = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [COLD_W-1:0] cold_cnt_q, cold_cnt_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  high_sh_q, high_sh_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [CNT_W-1:0]  high_act_q, high_act_d;
  logic              in_count;
  logic              wrap_int;

  // Start count for channel k; offsets beyond the active period fall back to 0.
  function automatic logic [CNT_W-1:0] start_val(input int unsigned k, input logic [CNT_W-1:0] per);
    int unsigned ofs;
    ofs = k * PHASE_STEP_EFF;
    if (ofs > 32'(per)) return '0;
    return CNT_W'(ofs);
  endfunction

  assign in_count = (state_q == S_COUNT);
  assign wrap_int = in_count && (cnt_q[0] == period_act_q);

  // Next state, cold-boot counter and per-channel counts.
  always_comb begin
    state_d    = state_q;
    cold_cnt_d = cold_cnt_q;
    for (int k = 0; k < NUM_CH; k++) cnt_d[k] = cnt_q[k];
    if (!en) begin
      state_d    = S_COLD_BOOT;
      cold_cnt_d = '0;
      for (int k = 0; k < NUM_CH; k++) cnt_d[k] = '0;
    end else if (state_q == S_COLD_BOOT) begin
      if (cold_cnt_q == COLD_W'(COLD_BOOT_CYCLE)) begin
        state_d    = S_COUNT;
        cold_cnt_d = '0;
        for (int k = 0; k < NUM_CH; k++) cnt_d[k] = start_val(k, period_act_q);
      end else begin
        cold_cnt_d = cold_cnt_q + COLD_W'(1);
      end
    end else begin
      // >= keeps a phased channel bounded if a shorter period lands while it is past the new end.
      for (int k = 0; k < NUM_CH; k++)
        cnt_d[k] = (cnt_q[k] >= period_act_q) ? '0 : cnt_q[k] + CNT_W'(1);
    end
  end

  // Shadow writes; active copies shadows throughout cold boot and on channel-0 wrap.
  always_comb begin
    period_sh_d  = period_sh_q;
    high_sh_d    = high_sh_q;
    period_act_d = period_act_q;
    high_act_d   = high_act_q;
    if (cfg_we && !cfg_addr) period_sh_d = cfg_wdata;
    if (cfg_we &&  cfg_addr) high_sh_d   = cfg_wdata;
    if (!in_count || wrap_int) begin
      period_act_d = period_sh_q;
      high_act_d   = high_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLD_BOOT;
      cold_cnt_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      period_sh_q  <= CNT_W'(FULL_CYCLE);
      high_sh_q    <= CNT_W'(OUTPUT_UP_PERIOD);
      period_act_q <= CNT_W'(FULL_CYCLE);
      high_act_q   <= CNT_W'(OUTPUT_UP_PERIOD);
    end else begin
      state_q      <= state_d;
      cold_cnt_q   <= cold_cnt_d;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      period_sh_q  <= period_sh_d;
      high_sh_q    <= high_sh_d;
      period_act_q <= period_act_d;
      high_act_q   <= high_act_d;
    end
  end

  always_comb begin
    o = '0;
    for (int k = 0; k < NUM_CH; k++) o[k] = in_count && (cnt_q[k] < high_act_q);
  end

  assign cnt0     = cnt_q[0];
  assign wrap     = wrap_int;
  assign counting = in_count;

endmodule
